// File: rtl/wavetable_pkg.sv
// Shared types and constants for the wavetable oscillator: FSM encoding,
// interpolation fraction width and the fixed values of the unused write-side memory ports.
package wavetable_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE0,
        WAIT0,
        ISSUE1,
        WAIT1,
        CALC,
        OUT
    } state_e;

    localparam int FRAC_BITS = 8;

    localparam logic       MEM_WRITE_TIE     = 1'b0;
    localparam logic       MEM_CLKEN_TIE     = 1'b1;
    localparam logic       MEM_DEBUG_TIE     = 1'b0;
    localparam logic [1:0] MEM_BYTEEN_TIE    = 2'b11;

endpackage

// File: rtl/wavetable_mem_reader_if.sv
// Memory-side (Avalon s1) and codec-side (valid/ready sample stream) signals of the reader.
// master = the reader, slave = memory plus sample consumer.
interface wavetable_mem_reader_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
);
    logic [ADDR_W-1:0] mem_address;
    logic              mem_chipselect;
    logic              mem_write;
    logic              mem_clken;
    logic              mem_debugaccess;
    logic [1:0]        mem_byteenable;
    logic [DATA_W-1:0] mem_writedata;
    logic [DATA_W-1:0] mem_readdata;
    logic [DATA_W-1:0] sample_data;
    logic              sample_valid;
    logic              sample_ready;

    modport master (
        output mem_address, mem_chipselect, mem_write, mem_clken, mem_debugaccess,
               mem_byteenable, mem_writedata, sample_data, sample_valid,
        input  mem_readdata, sample_ready
    );

    modport slave (
        input  mem_address, mem_chipselect, mem_write, mem_clken, mem_debugaccess,
               mem_byteenable, mem_writedata, sample_data, sample_valid,
        output mem_readdata, sample_ready
    );
endinterface

// File: rtl/wt_interp.sv
// Linear interpolation s0 + floor((s1 - s0) * f / 256); purely combinational, zero latency.
// The result always lands between s0 and s1, so the low DATA_W bits of the sum are exact.
module wt_interp
    import wavetable_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic signed [DATA_W-1:0]    s0_i,
    input  logic signed [DATA_W-1:0]    s1_i,
    input  logic        [FRAC_BITS-1:0] f_i,
    output logic signed [DATA_W-1:0]    sample_o
);
    logic signed [DATA_W:0]           diff;
    logic signed [DATA_W+FRAC_BITS:0] prod;
    logic signed [DATA_W+FRAC_BITS:0] sum;

    always_comb begin
        diff     = {s1_i[DATA_W-1], s1_i} - {s0_i[DATA_W-1], s0_i};
        prod     = diff * $signed({1'b0, f_i});
        sum      = (prod >>> FRAC_BITS) + {{(FRAC_BITS+1){s0_i[DATA_W-1]}}, s0_i};
        sample_o = DATA_W'(sum);
    end
endmodule

// File: rtl/wavetable_mem_reader.sv
// Wavetable oscillator: per sample tick reads two adjacent table words over Avalon-MM and interpolates.
// Sample valid 4 + 2*READ_LATENCY cycles after the tick; held until ready, ticks arriving meanwhile set overrun.
module wavetable_mem_reader
    import wavetable_pkg::*;
#(
    parameter int ADDR_W       = 8,
    parameter int DATA_W       = 16,
    parameter int PHASE_W      = 24,
    parameter int READ_LATENCY = 1
) (
    input  logic                   clk_clk,
    input  logic                   reset_reset_n,
    input  logic                   enable,
    input  logic                   sample_tick,
    input  logic [PHASE_W-1:0]     phase_inc,
    wavetable_mem_reader_if.master bus,
    output logic                   overrun,
    output logic                   busy
);
    localparam logic [1:0] LAST_WAIT = 2'(READ_LATENCY - 1);

    state_e                state_q, state_d;
    logic [PHASE_W-1:0]    phase_q, phase_d;
    logic [ADDR_W-1:0]     idx_q, idx_d;
    logic [FRAC_BITS-1:0]  frac_q, frac_d;
    logic [DATA_W-1:0]     s0_q, s0_d;
    logic [DATA_W-1:0]     s1_q, s1_d;
    logic [1:0]            cnt_q, cnt_d;
    logic [DATA_W-1:0]     sample_q, sample_d;
    logic                  valid_q, valid_d;
    logic                  overrun_q, overrun_d;
    logic [DATA_W-1:0]     interp;

    wt_interp #(.DATA_W(DATA_W)) u_interp (
        .s0_i     (s0_q),
        .s1_i     (s1_q),
        .f_i      (frac_q),
        .sample_o (interp)
    );

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state_q   <= IDLE;
            phase_q   <= '0;
            idx_q     <= '0;
            frac_q    <= '0;
            s0_q      <= '0;
            s1_q      <= '0;
            cnt_q     <= '0;
            sample_q  <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            idx_q     <= idx_d;
            frac_q    <= frac_d;
            s0_q      <= s0_d;
            s1_q      <= s1_d;
            cnt_q     <= cnt_d;
            sample_q  <= sample_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        idx_d     = idx_q;
        frac_d    = frac_q;
        s0_d      = s0_q;
        s1_d      = s1_q;
        cnt_d     = cnt_q;
        sample_d  = sample_q;
        valid_d   = 1'b0;
        overrun_d = overrun_q;

        if (!enable)
            overrun_d = 1'b0;
        else if (sample_tick && state_q != IDLE)
            overrun_d = 1'b1;

        case (state_q)
            IDLE: begin
                if (!enable) begin
                    phase_d = '0;
                end else if (sample_tick) begin
                    idx_d   = phase_q[PHASE_W-1 -: ADDR_W];
                    frac_d  = phase_q[PHASE_W-ADDR_W-1 -: FRAC_BITS];
                    state_d = ISSUE0;
                end
            end
            ISSUE0: begin
                cnt_d   = '0;
                state_d = WAIT0;
            end
            WAIT0: begin
                if (cnt_q == LAST_WAIT) begin
                    s0_d    = bus.mem_readdata;
                    state_d = ISSUE1;
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
            ISSUE1: begin
                cnt_d   = '0;
                state_d = WAIT1;
            end
            WAIT1: begin
                if (cnt_q == LAST_WAIT) begin
                    s1_d    = bus.mem_readdata;
                    state_d = CALC;
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
            CALC: begin
                sample_d = interp;
                phase_d  = phase_q + phase_inc;
                state_d  = OUT;
            end
            OUT: begin
                // valid is a flop, so the first OUT cycle only raises it
                if (valid_q && bus.sample_ready)
                    state_d = IDLE;
                else
                    valid_d = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.mem_address    = '0;
        bus.mem_chipselect = 1'b0;
        if (state_q == ISSUE0) begin
            bus.mem_address    = idx_q;
            bus.mem_chipselect = 1'b1;
        end else if (state_q == ISSUE1) begin
            bus.mem_address    = idx_q + ADDR_W'(1);
            bus.mem_chipselect = 1'b1;
        end
    end

    assign bus.mem_write       = MEM_WRITE_TIE;
    assign bus.mem_clken       = MEM_CLKEN_TIE;
    assign bus.mem_debugaccess = MEM_DEBUG_TIE;
    assign bus.mem_byteenable  = MEM_BYTEEN_TIE;
    assign bus.mem_writedata   = '0;
    assign bus.sample_data     = sample_q;
    assign bus.sample_valid    = valid_q;
    assign overrun             = overrun_q;
    assign busy                = (state_q != IDLE);
endmodule

// File: tb/tb_wavetable_mem_reader.sv
// Bench for wavetable_mem_reader: two instances (read latency 1 and 3) share stimulus and table contents;
// a tick model queues expected addresses and samples, monitors pop and compare.
module tb_wavetable_mem_reader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic        sample_tick = 1'b0;
    logic [23:0] phase_inc = '0;
    logic        ready = 1'b1;
    logic        ovr1, ovr3, busy1, busy3;

    logic signed [15:0] mem_tb [0:255];
    logic [15:0]        pipe1;
    logic [15:0]        pipe3 [0:2];

    int n_vec = 0;
    int n_err = 0;
    int qa1[$], qa3[$], qs1[$], qs3[$];
    logic [23:0] phase_m = '0;

    always #5 clk = ~clk;

    wavetable_mem_reader_if #(.ADDR_W(8), .DATA_W(16)) bus1 ();
    wavetable_mem_reader_if #(.ADDR_W(8), .DATA_W(16)) bus3 ();

    wavetable_mem_reader #(.READ_LATENCY(1)) dut1 (
        .clk_clk(clk), .reset_reset_n(rst_n), .enable(enable), .sample_tick(sample_tick),
        .phase_inc(phase_inc), .bus(bus1.master), .overrun(ovr1), .busy(busy1)
    );
    wavetable_mem_reader #(.READ_LATENCY(3)) dut3 (
        .clk_clk(clk), .reset_reset_n(rst_n), .enable(enable), .sample_tick(sample_tick),
        .phase_inc(phase_inc), .bus(bus3.master), .overrun(ovr3), .busy(busy3)
    );

    always @(posedge clk) begin
        pipe1    <= mem_tb[bus1.mem_address];
        pipe3[0] <= mem_tb[bus3.mem_address];
        pipe3[1] <= pipe3[0];
        pipe3[2] <= pipe3[1];
    end
    assign bus1.mem_readdata = pipe1;
    assign bus3.mem_readdata = pipe3[2];
    assign bus1.sample_ready = ready;
    assign bus3.sample_ready = ready;

    task automatic check(input string tag, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic push_tick();
        int idx, f, s0, s1, e;
        idx = int'(phase_m[23:16]);
        f   = int'(phase_m[15:8]);
        s0  = mem_tb[idx];
        s1  = mem_tb[(idx + 1) % 256];
        e   = s0 + (((s1 - s0) * f) >>> 8);
        qa1.push_back(idx); qa1.push_back((idx + 1) % 256);
        qa3.push_back(idx); qa3.push_back((idx + 1) % 256);
        qs1.push_back(e);
        qs3.push_back(e);
        phase_m = phase_m + phase_inc;
    endtask

    // Called at a negedge; returns at the negedge after the tick edge.
    task automatic do_tick();
        int n = 0;
        while ((busy1 || busy3) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) check("tick_wait_idle", int'(busy1 | busy3), 0);
        if (enable) push_tick();
        sample_tick = 1'b1;
        @(posedge clk);
        @(negedge clk);
        sample_tick = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((qs1.size() != 0 || qs3.size() != 0 || qa1.size() != 0 || qa3.size() != 0
                || busy1 || busy3) && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("drain_qs1", qs1.size(), 0);
        check("drain_qs3", qs3.size(), 0);
        check("drain_busy", int'(busy1 | busy3), 0);
    endtask

    task automatic clear_phase();
        enable = 1'b0;
        repeat (2) @(negedge clk);
        phase_m = '0;
        enable = 1'b1;
    endtask

    task automatic wait_both_valid();
        int n = 0;
        while (!(bus1.sample_valid && bus3.sample_valid) && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (n >= 60) check("valid_timeout", int'(bus1.sample_valid & bus3.sample_valid), 1);
    endtask

    always @(negedge clk) begin
        #1;
        if (rst_n) begin
            if (bus1.mem_chipselect) begin
                if (qa1.size() == 0) check("cs1_extra", int'(bus1.mem_address), -1);
                else check("addr1", int'(bus1.mem_address), qa1.pop_front());
            end
            if (bus1.sample_valid && bus1.sample_ready) begin
                if (qs1.size() == 0) check("samp1_extra", $signed(bus1.sample_data), -99999);
                else check("samp1", $signed(bus1.sample_data), qs1.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        #1;
        if (rst_n) begin
            if (bus3.mem_chipselect) begin
                if (qa3.size() == 0) check("cs3_extra", int'(bus3.mem_address), -1);
                else check("addr3", int'(bus3.mem_address), qa3.pop_front());
            end
            if (bus3.sample_valid && bus3.sample_ready) begin
                if (qs3.size() == 0) check("samp3_extra", $signed(bus3.sample_data), -99999);
                else check("samp3", $signed(bus3.sample_data), qs3.pop_front());
            end
        end
    end

    initial begin
        int lat1, lat3, chg1, chg3, cs_cnt, vcnt;
        logic [15:0] d1, d3;

        for (int i = 0; i < 256; i++) mem_tb[i] = 16'(100 * i);
        repeat (3) @(negedge clk);

        // reset values
        check("rst_cs1",     int'(bus1.mem_chipselect), 0);
        check("rst_addr1",   int'(bus1.mem_address), 0);
        check("rst_write1",  int'(bus1.mem_write), 0);
        check("rst_clken1",  int'(bus1.mem_clken), 1);
        check("rst_dbg1",    int'(bus1.mem_debugaccess), 0);
        check("rst_be1",     int'(bus1.mem_byteenable), 3);
        check("rst_wdata1",  int'(bus1.mem_writedata), 0);
        check("rst_valid1",  int'(bus1.sample_valid), 0);
        check("rst_data1",   int'(bus1.sample_data), 0);
        check("rst_ovr1",    int'(ovr1), 0);
        check("rst_busy1",   int'(busy1), 0);
        check("rst_valid3",  int'(bus3.sample_valid), 0);
        check("rst_busy3",   int'(busy3), 0);
        check("rst_clken3",  int'(bus3.mem_clken), 1);
        rst_n = 1'b1;
        @(negedge clk);
        enable = 1'b1;

        // linear ramp with latency measurement on the first tick
        phase_inc = 24'h010000;
        @(negedge clk);
        do_tick();
        lat1 = 0;
        lat3 = 0;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk);
            #1;
            if (bus1.sample_valid && lat1 == 0) lat1 = n;
            if (bus3.sample_valid && lat3 == 0) lat3 = n;
        end
        check("latency_rl1", lat1, 6);
        check("latency_rl3", lat3, 10);
        @(negedge clk);
        repeat (3) do_tick();
        drain();

        // wrap from index 255 to 0
        clear_phase();
        mem_tb[255] = 16'sd1000;
        mem_tb[0]   = 16'sd0;
        mem_tb[1]   = 16'sd400;
        phase_inc = 24'hFF8000;
        do_tick();
        drain();
        phase_inc = 24'h010000;
        do_tick();
        do_tick();
        drain();

        // negative slope
        clear_phase();
        mem_tb[0] = 16'sd1000;
        mem_tb[1] = -16'sd1000;
        phase_inc = 24'h004000;
        repeat (2) do_tick();
        drain();

        // extreme values
        clear_phase();
        mem_tb[0] = -16'sd32768;
        mem_tb[1] = 16'sd32767;
        phase_inc = 24'h00FF00;
        repeat (2) do_tick();
        drain();

        // backpressure with a tick dropped mid-stall
        clear_phase();
        phase_inc = 24'h010000;
        ready = 1'b0;
        do_tick();
        wait_both_valid();
        d1 = bus1.sample_data;
        d3 = bus3.sample_data;
        chg1 = 0;
        chg3 = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            sample_tick = (i == 5);
            if (bus1.sample_data !== d1 || !bus1.sample_valid) chg1++;
            if (bus3.sample_data !== d3 || !bus3.sample_valid) chg3++;
        end
        sample_tick = 1'b0;
        check("bp_stable1", chg1, 0);
        check("bp_stable3", chg3, 0);
        check("bp_ovr1", int'(ovr1), 1);
        check("bp_ovr3", int'(ovr3), 1);
        ready = 1'b1;
        drain();
        enable = 1'b0;
        @(negedge clk);
        check("ovr_clr1", int'(ovr1), 0);
        check("ovr_clr3", int'(ovr3), 0);

        // tick on the same edge as the output handshake
        clear_phase();
        ready = 1'b0;
        do_tick();
        wait_both_valid();
        @(negedge clk);
        ready = 1'b1;
        sample_tick = 1'b1;
        @(negedge clk);
        sample_tick = 1'b0;
        check("hs_tick_ovr1", int'(ovr1), 1);
        check("hs_tick_ovr3", int'(ovr3), 1);
        drain();

        // async reset during WAIT1 of the latency-1 instance
        clear_phase();
        phase_inc = 24'h030000;
        repeat (2) do_tick();
        drain();
        do_tick();
        cs_cnt = 0;
        for (int n = 0; n < 20; n++) begin
            if (bus1.mem_chipselect) cs_cnt++;
            if (cs_cnt == 2) break;
            @(posedge clk);
            #1;
        end
        check("rst_test_cs_seen", cs_cnt, 2);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_busy1",  int'(busy1), 0);
        check("arst_cs1",    int'(bus1.mem_chipselect), 0);
        check("arst_addr1",  int'(bus1.mem_address), 0);
        check("arst_valid1", int'(bus1.sample_valid), 0);
        check("arst_data1",  int'(bus1.sample_data), 0);
        check("arst_ovr1",   int'(ovr1), 0);
        check("arst_busy3",  int'(busy3), 0);
        qa1.delete();
        qa3.delete();
        qs1.delete();
        qs3.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        phase_m = '0;
        vcnt = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bus1.sample_valid || bus3.sample_valid) vcnt++;
        end
        check("no_valid_after_rst", vcnt, 0);
        phase_inc = 24'h010000;
        do_tick();
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
